// File: rtl/core.sv
// core: receives two Q8.8 operands as four bytes from a UART receiver,
// adds them with saturation, and sends the 16-bit result back MSB first
// through a UART transmitter using a strobe/done handshake.
module core (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Rx_Byte_in,
  input  logic       Rx_DV_in,
  input  logic       Tx_Done_in,
  output logic       Tx_DV_out,
  output logic [7:0] Tx_Byte_out,
  output logic [7:0] c_out
);

  typedef enum logic [2:0] {
    ST_RX       = 3'd0,
    ST_CALC     = 3'd1,
    ST_TX_MSB   = 3'd2,
    ST_WAIT_MSB = 3'd3,
    ST_TX_LSB   = 3'd4,
    ST_WAIT_LSB = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  c_out_q, c_out_d;

  logic [16:0] sum_ext;
  logic [15:0] sum_sat;

  // Sign-extended add; a mismatch between the top two bits signals overflow,
  // and the carry-out bit tells which rail to clamp to.
  always_comb begin
    sum_ext = {a_q[15], a_q} + {b_q[15], b_q};
    sum_sat = sum_ext[15:0];
    if (sum_ext[16] != sum_ext[15]) begin
      sum_sat = sum_ext[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Next-state logic; the transmit byte and strobe are set up on the edge
  // that enters a TX state so they are valid for the whole TX cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    c_out_d   = c_out_q;

    case (state_q)
      ST_RX: begin
        if (Rx_DV_in) begin
          case (cnt_q)
            2'd0:    a_d[15:8] = Rx_Byte_in;
            2'd1:    a_d[7:0]  = Rx_Byte_in;
            2'd2:    b_d[15:8] = Rx_Byte_in;
            default: b_d[7:0]  = Rx_Byte_in;
          endcase
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = ST_CALC;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_CALC: begin
        c_d       = sum_sat;
        c_out_d   = sum_sat[15:8];
        tx_byte_d = sum_sat[15:8];
        tx_dv_d   = 1'b1;
        state_d   = ST_TX_MSB;
      end

      ST_TX_MSB: begin
        state_d = ST_WAIT_MSB;
      end

      ST_WAIT_MSB: begin
        if (Tx_Done_in) begin
          tx_byte_d = c_q[7:0];
          tx_dv_d   = 1'b1;
          state_d   = ST_TX_LSB;
        end
      end

      ST_TX_LSB: begin
        state_d = ST_WAIT_LSB;
      end

      ST_WAIT_LSB: begin
        if (Tx_Done_in) begin
          state_d = ST_RX;
        end
      end

      default: begin
        state_d = ST_RX;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_RX;
      cnt_q     <= 2'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      c_q       <= 16'h0000;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      c_out_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      c_out_q   <= c_out_d;
    end
  end

  assign Tx_DV_out   = tx_dv_q;
  assign Tx_Byte_out = tx_byte_q;
  assign c_out       = c_out_q;

endmodule

// File: tb/tb_core.sv
// Directed testbench for core: byte assembly, saturating add, MSB/LSB
// transmit handshake, dropped strobes outside RX, and mid-transaction reset.
module tb_core;

  logic       CLK;
  logic       RST;
  logic [7:0] Rx_Byte_in;
  logic       Rx_DV_in;
  logic       Tx_Done_in;
  logic       Tx_DV_out;
  logic [7:0] Tx_Byte_out;
  logic [7:0] c_out;

  int checkCount = 0;
  int failCount  = 0;

  core dut (
    .CLK         (CLK),
    .RST         (RST),
    .Rx_Byte_in  (Rx_Byte_in),
    .Rx_DV_in    (Rx_DV_in),
    .Tx_Done_in  (Tx_Done_in),
    .Tx_DV_out   (Tx_DV_out),
    .Tx_Byte_out (Tx_Byte_out),
    .c_out       (c_out)
  );

  // Free-running 100 MHz clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle receive strobe, driven on the falling edge
  task automatic sendByte(input logic [7:0] b);
    @(negedge CLK);
    Rx_Byte_in = b;
    Rx_DV_in   = 1'b1;
    @(negedge CLK);
    Rx_DV_in   = 1'b0;
  endtask

  // Four operand bytes in A-high, A-low, B-high, B-low order
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    sendByte(a[15:8]);
    sendByte(a[7:0]);
    sendByte(b[15:8]);
    sendByte(b[7:0]);
  endtask

  // One-cycle transmitter-done strobe
  task automatic pulseDone();
    @(negedge CLK);
    Tx_Done_in = 1'b1;
    @(negedge CLK);
    Tx_Done_in = 1'b0;
  endtask

  // Full operand/result exchange with hand-computed expected sum
  task automatic runTxn(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expC, input int waitCycles,
                        input bit injectStray);
    logic sawPulse;
    applyStimulus(a, b);
    checkOutput({tag, "_calc_dv"}, {15'd0, Tx_DV_out}, 16'd0);
    @(negedge CLK);
    checkOutput({tag, "_msb_dv"}, {15'd0, Tx_DV_out}, 16'd1);
    checkOutput({tag, "_msb_byte"}, {8'd0, Tx_Byte_out}, {8'd0, expC[15:8]});
    checkOutput({tag, "_c_out"}, {8'd0, c_out}, {8'd0, expC[15:8]});
    @(negedge CLK);
    checkOutput({tag, "_msb_dv_drop"}, {15'd0, Tx_DV_out}, 16'd0);
    checkOutput({tag, "_msb_hold"}, {8'd0, Tx_Byte_out}, {8'd0, expC[15:8]});
    sawPulse = 1'b0;
    if (injectStray) begin
      sendByte(8'hAA);
      sawPulse = Tx_DV_out;
    end
    for (int i = 0; i < waitCycles; i++) begin
      @(negedge CLK);
      if (Tx_DV_out) sawPulse = 1'b1;
    end
    checkOutput({tag, "_wait_no_dv"}, {15'd0, sawPulse}, 16'd0);
    pulseDone();
    checkOutput({tag, "_lsb_dv"}, {15'd0, Tx_DV_out}, 16'd1);
    checkOutput({tag, "_lsb_byte"}, {8'd0, Tx_Byte_out}, {8'd0, expC[7:0]});
    checkOutput({tag, "_c_out_hold"}, {8'd0, c_out}, {8'd0, expC[15:8]});
    @(negedge CLK);
    checkOutput({tag, "_lsb_dv_drop"}, {15'd0, Tx_DV_out}, 16'd0);
    pulseDone();
    checkOutput({tag, "_end_dv"}, {15'd0, Tx_DV_out}, 16'd0);
  endtask

  // Directed scenario sequence
  initial begin
    logic sawPulse;
    RST        = 1'b0;
    Rx_Byte_in = 8'h00;
    Rx_DV_in   = 1'b0;
    Tx_Done_in = 1'b0;

    repeat (3) @(negedge CLK);
    checkOutput("rst_dv", {15'd0, Tx_DV_out}, 16'd0);
    checkOutput("rst_byte", {8'd0, Tx_Byte_out}, 16'h0000);
    checkOutput("rst_c_out", {8'd0, c_out}, 16'h0000);
    RST = 1'b1;

    $display("[TB] basic add 1234 + FF80");
    runTxn("basic", 16'h1234, 16'hFF80, 16'h11B4, 25, 1'b0);

    $display("[TB] positive saturation");
    runTxn("possat", 16'h7F00, 16'h0200, 16'h7FFF, 3, 1'b0);

    $display("[TB] negative saturation");
    runTxn("negsat", 16'h8000, 16'hFF00, 16'h8000, 3, 1'b0);

    $display("[TB] stray byte during WAIT_MSB");
    runTxn("stray", 16'h0100, 16'h0200, 16'h0300, 2, 1'b1);
    runTxn("after_stray", 16'h0005, 16'h0003, 16'h0008, 2, 1'b0);

    $display("[TB] Tx_Done while idle in RX");
    runTxn("pre_idle", 16'h1234, 16'h1111, 16'h2345, 2, 1'b0);
    sawPulse = 1'b0;
    pulseDone();
    if (Tx_DV_out) sawPulse = 1'b1;
    pulseDone();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (Tx_DV_out) sawPulse = 1'b1;
    end
    checkOutput("idle_done_no_dv", {15'd0, sawPulse}, 16'd0);
    checkOutput("idle_byte_hold", {8'd0, Tx_Byte_out}, 16'h0045);
    checkOutput("idle_c_out_hold", {8'd0, c_out}, 16'h0023);
    runTxn("after_idle", 16'hFFFF, 16'h0002, 16'h0001, 2, 1'b0);

    $display("[TB] reset after two bytes");
    runTxn("pre_rst", 16'h1234, 16'h1111, 16'h2345, 2, 1'b0);
    sendByte(8'h12);
    sendByte(8'h34);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("midrst_dv", {15'd0, Tx_DV_out}, 16'd0);
    checkOutput("midrst_byte", {8'd0, Tx_Byte_out}, 16'h0000);
    checkOutput("midrst_c_out", {8'd0, c_out}, 16'h0000);
    sawPulse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (Tx_DV_out) sawPulse = 1'b1;
    end
    checkOutput("midrst_no_dv", {15'd0, sawPulse}, 16'd0);
    RST = 1'b1;
    runTxn("post_rst", 16'h0001, 16'h0002, 16'h0003, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 Rx_Byte_in  input  8  byte from UART receiver; sampled only when Rx_DV_in=1.
REQ-005 Rx_DV_in  input  1  one-cycle strobe marking a valid received byte.
REQ-006 Tx_Done_in  input  1  one-cycle strobe from UART transmitter marking the current byte as sent.
REQ-007 Tx_DV_out  output  1  one-cycle strobe requesting transmission of Tx_Byte_out.
REQ-008 Tx_Byte_out  output  8  byte for the transmitter; stable from its Tx_DV_out pulse until the next pulse.
REQ-009 c_out  output  8  high byte of the most recent sum, for LED/debug.

Function
REQ-010 Operands A and B SHALL be 16-bit two's-complement Q8.8 values.
REQ-011 Received bytes SHALL be assembled in the order A[15:8], A[7:0], B[15:8], B[7:0].
- A 2-bit byte counter increments on each accepted Rx_DV_in.
REQ-012 FSM states SHALL be: RX, CALC, TX_MSB, WAIT_MSB, TX_LSB, WAIT_LSB.
REQ-013 RX: capture each strobed byte into its slot; after the 4th byte, go to CALC and clear the counter.
REQ-014 CALC (one cycle): compute C = A + B with 17-bit internal width, saturated to 16 bits.
- Positive overflow gives 16'h7FFF; negative overflow gives 16'h8000.
- C is registered.
- c_out is loaded with C[15:8].
REQ-015 TX_MSB (one cycle): load Tx_Byte_out = C[15:8], pulse Tx_DV_out for exactly one cycle, then go to WAIT_MSB.
REQ-016 WAIT_MSB: hold until Tx_Done_in=1, then go to TX_LSB.
REQ-017 TX_LSB (one cycle): load Tx_Byte_out = C[7:0], pulse Tx_DV_out for exactly one cycle, then go to WAIT_LSB.
REQ-018 WAIT_LSB: hold until Tx_Done_in=1, then return to RX ready for a new operand set.
REQ-019 Latency: Tx_DV_out SHALL be high in the 2nd cycle after the edge that samples the 4th Rx_DV_in (one CALC cycle, then TX_MSB).
REQ-020 Rx_DV_in SHALL be ignored in all states except RX; bytes arriving then are dropped and the counter does not change.
REQ-021 Tx_Done_in SHALL be ignored outside WAIT_MSB and WAIT_LSB.
REQ-022 Tx_DV_out SHALL never be asserted on two consecutive cycles.
REQ-023 Wait times in WAIT_MSB and WAIT_LSB SHALL be unbounded, with no timeout.
REQ-024 c_out and Tx_Byte_out SHALL hold their last values until overwritten by a later CALC or TX state.

Reset
REQ-025 While RST=0, regardless of clock:
- state = RX, byte counter = 0;
- A, B and C = 0;
- Tx_DV_out = 0, Tx_Byte_out = 8'h00, c_out = 8'h00.
REQ-026 Reset asserted mid-operation (any state) SHALL abort the transaction with no further Tx_DV_out pulse.
- After release, a fresh 4-byte sequence is required.
REQ-027 After RST rises, the first Rx_DV_in sampled at a rising edge SHALL be accepted as A[15:8].

Verification
REQ-028 Send 12,34,FF,80, then Tx_Done_in 25 cycles after the first pulse:
- first pulse carries Tx_Byte_out=11 and c_out=11;
- the second pulse follows Tx_Done_in with Tx_Byte_out=B4;
- a second Tx_Done_in returns the FSM to RX.
REQ-029 Send 7F,00,02,00 -> C=7FFF: Tx bytes 7F then FF, c_out=7F (positive saturation).
REQ-030 Send 80,00,FF,00 -> C=8000: Tx bytes 80 then 00 (negative saturation).
REQ-031 Strobe Rx_DV_in while in WAIT_MSB -> byte ignored; the next transaction's result still uses the next 4 bytes correctly.
REQ-032 Assert RST=0 after 2 received bytes, release, send 00,01,00,02 -> Tx bytes 00 then 03; no Tx_DV_out during reset.
REQ-033 Pulse Tx_Done_in while in RX with no pending transmit -> no state change and no Tx_DV_out.
